tempo_divider: RTL and testbench
================================

# tempo_divider

Multi-channel programmable clock divider generating the drum machine's tempo and step timing from the system clock. Each channel produces a one-cycle tick strobe and a 50%-duty square wave from its own run-time divisor. Divisor changes take effect only at a channel's period boundary, so tempo changes never glitch. A global sync input phase-aligns all channels, for example on sequencer start.

## Interface
- CHANNELS, 4: number of independent divider channels (≥1).
- WIDTH, 16: divisor and counter width in bits.
- RESET_DIV, 3: divisor loaded into every channel at reset (< 2^WIDTH).

- clk_rx  in  1: system clock; all logic is on its rising edge.
- nrst  in  1: asynchronous, active-low reset.
- en  in  1: global run enable.
- sync  in  1: synchronous restart of all channels.
- div_we  in  1: divisor write strobe.
- div_sel  in  max(1,$clog2(CHANNELS)): channel addressed by the write.
- div_data  in  WIDTH: divisor value D to write.
- tick  out  CHANNELS: per-channel one-cycle strobe, registered.
- clk_tx  out  CHANNELS: per-channel square wave, registered.

## Operation
Per-channel state:
- shadow divisor S
- active divisor D
- counter C, WIDTH bits
- tick and clk_tx registers

Divisor write:
- When div_we=1, S[div_sel] <= div_data.
- A div_sel value ≥ CHANNELS is ignored.

Priority per edge is sync, then en=0, then count.
- sync=1 (regardless of en):
  - C <= 0, clk_tx <= 0, tick <= 0.
  - D <= S, including a same-cycle write.
- en=0 and sync=0:
  - C and clk_tx hold; tick <= 0.
  - Writes to S still land.
- en=1, C≠D: C <= C+1, tick <= 0.
- en=1, C==D (wrap):
  - C <= 0, tick <= 1, clk_tx <= ~clk_tx.
  - D <= S. If the same channel is written in this cycle, D takes the written value.

Arithmetic:
- Wrap interval is D+1 cycles.
- clk_tx period is 2·(D+1) cycles, 50% duty.
- D=0: tick held high every enabled cycle; clk_tx toggles every cycle.
- D=2^WIDTH−1 is legal. C never exceeds D, so there is no overflow.

Other rules:
- Channels are fully independent except for the shared en and sync.
- A write to one channel never disturbs another channel's counting.

## Timing
- Reset (asynchronous, takes effect without a clock):
  - tick=0, clk_tx=0, C=0.
  - S=D=RESET_DIV.
- First tick after reset release, with en=1 from the first edge: visible after edge D+1.
- tick and the clk_tx toggle change on the same edge. A tick accompanies every clk_tx edge.
- New divisor latency:
  - The current interval completes with the old D.
  - The next interval uses the new D.
  - Worst case D_old+1 cycles after the write.
- After sync: the next tick arrives D+1 cycles after the sync edge on every channel, using the newly applied D.
- Reset asserted mid-count aborts immediately. No partial pulse is stretched.

## Structure
- Package tempo_pkg holds:
  - default CHANNELS, WIDTH and RESET_DIV constants.
  - a divisor typedef, logic [WIDTH-1:0].
- Sub-module div_channel:
  - holds one channel's S, D, C, tick and clk_tx.
  - inputs: clk_rx, nrst, en, sync, a local write strobe and the data.
  - the top level decodes div_sel into CHANNELS per-channel write strobes and instantiates div_channel in a generate loop.

## Test plan
- Basic count: reset with RESET_DIV=3, en=1.
  - Each tick is first high after edge 4, then every 4 cycles.
  - clk_tx period is 8 cycles; all channels are identical.
- Divisor write mid-count: write D=9 to channel 1 at C=1.
  - Channel 1 finishes its 4-cycle interval, then ticks every 10 cycles (clk_tx period 20).
  - Channels 0, 2 and 3 are unaffected.
- D=0, and write-at-wrap: write D=0.
  - After the boundary, tick stays high while en=1 and clk_tx toggles every cycle.
  - Then write D=5 in the exact wrap cycle: the next interval is 6 cycles.
- Sync alignment: sync pulsed with channels at different phases.
  - Next edge: all C=0, clk_tx=0, tick=0, and pending shadow divisors are applied.
  - Ticks are aligned afterwards; a channel with D=3 next ticks 4 cycles later.
- Enable hold: en low for 5 cycles at C=2 (D=3).
  - tick is low and clk_tx holds during the hold.
  - After en returns high, the tick follows 2 cycles later.
- Async reset: nrst asserted between clock edges while clk_tx=1.
  - Outputs go to 0 before the next edge.
  - After release, D=3 and the count resumes from zero.

Source files
------------

// File: rtl/tempo_divider_pkg.sv
// -----------------------------------------------------------------------------
// tempo_pkg
// Shared constants and types for the tempo divider slice.
//   DEF_CHANNELS  : default number of divider channels
//   DEF_WIDTH     : default divisor / counter width
//   DEF_RESET_DIV : default divisor loaded into every channel at reset
//   divisor_t     : divisor word at the default width
//   sel_width()   : width of the channel-select bus for a channel count
// -----------------------------------------------------------------------------
package tempo_pkg;

    localparam int DEF_CHANNELS  = 32'd4;
    localparam int DEF_WIDTH     = 32'd16;
    localparam int DEF_RESET_DIV = 32'd3;

    typedef logic [DEF_WIDTH-1:0] divisor_t;

    // A single-channel build still carries a 1-bit select so the port never
    // collapses to zero width.
    function automatic int sel_width(input int channels);
        int w;
        if (channels > 32'd1) begin
            w = $clog2(channels);
        end else begin
            w = 32'd1;
        end
        return w;
    endfunction

endpackage : tempo_pkg

// File: rtl/tempo_divider_div_channel.sv
// -----------------------------------------------------------------------------
// div_channel
// One programmable divider channel. Counts clk_rx edges from 0 up to the
// active divisor D, then wraps, emitting a one-cycle tick and toggling a
// 50%-duty square wave. New divisors are staged in a shadow register and only
// become active at a wrap (or on sync), so a tempo change never cuts an
// interval short.
//
// Ports
//   clk_rx : system clock, rising edge
//   nrst   : asynchronous active-low reset
//   en     : run enable (counter and clk_tx hold while low)
//   sync   : synchronous restart, outranks en
//   we     : divisor write strobe already decoded for this channel
//   data   : divisor value to write
//   tick   : registered one-cycle strobe at each wrap
//   clk_tx : registered square wave, toggles at each wrap
// -----------------------------------------------------------------------------
module div_channel
    import tempo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int RESET_DIV = DEF_RESET_DIV
) (
    input  logic             clk_rx,
    input  logic             nrst,
    input  logic             en,
    input  logic             sync,
    input  logic             we,
    input  logic [WIDTH-1:0] data,
    output logic             tick,
    output logic             clk_tx
);

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ZERO_VAL  = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] shadow_r;
    logic [WIDTH-1:0] active_r;
    logic [WIDTH-1:0] cnt_r;
    logic             tick_r;
    logic             clk_tx_r;

    logic [WIDTH-1:0] next_div_s;
    logic             wrap_s;

    // Divisor to adopt at the next boundary: a write in the same cycle wins
    // over the value already sitting in the shadow register.
    always_comb begin
        if (we) begin
            next_div_s = data;
        end else begin
            next_div_s = shadow_r;
        end
    end

    // The counter never passes the active divisor, so equality is the only
    // wrap condition needed and the all-ones divisor cannot overflow.
    always_comb begin
        if (cnt_r == active_r) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end
    end

    // Shadow divisor: writes land on every edge, regardless of en or sync.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            shadow_r <= RESET_VAL;
        end else if (we) begin
            shadow_r <= data;
        end else begin
            shadow_r <= shadow_r;
        end
    end

    // Counter, active divisor and output registers; priority sync > !en > count.
    always_ff @(posedge clk_rx or negedge nrst) begin
        if (!nrst) begin
            active_r <= RESET_VAL;
            cnt_r    <= ZERO_VAL;
            tick_r   <= 1'b0;
            clk_tx_r <= 1'b0;
        end else if (sync) begin
            // Restart phase-aligned with every other channel.
            active_r <= next_div_s;
            cnt_r    <= ZERO_VAL;
            tick_r   <= 1'b0;
            clk_tx_r <= 1'b0;
        end else if (!en) begin
            // Freeze the phase; only the strobe is forced low.
            active_r <= active_r;
            cnt_r    <= cnt_r;
            tick_r   <= 1'b0;
            clk_tx_r <= clk_tx_r;
        end else if (wrap_s) begin
            // Period boundary: the only point where a new divisor is adopted.
            active_r <= next_div_s;
            cnt_r    <= ZERO_VAL;
            tick_r   <= 1'b1;
            clk_tx_r <= ~clk_tx_r;
        end else begin
            active_r <= active_r;
            cnt_r    <= cnt_r + ONE_VAL;
            tick_r   <= 1'b0;
            clk_tx_r <= clk_tx_r;
        end
    end

    assign tick   = tick_r;
    assign clk_tx = clk_tx_r;

endmodule : div_channel

// File: rtl/tempo_divider.sv
// -----------------------------------------------------------------------------
// tempo_divider
// Multi-channel programmable clock divider producing tempo and step timing.
// Each channel has its own run-time divisor D and generates a tick every D+1
// enabled cycles plus a square wave of period 2*(D+1). A shared sync input
// restarts all channels in phase.
//
// Ports
//   clk_rx   : system clock, rising edge
//   nrst     : asynchronous active-low reset
//   en       : global run enable
//   sync     : synchronous restart of all channels
//   div_we   : divisor write strobe
//   div_sel  : channel addressed by the write (out-of-range values ignored)
//   div_data : divisor value
//   tick     : per-channel one-cycle strobe, registered
//   clk_tx   : per-channel square wave, registered
// -----------------------------------------------------------------------------
module tempo_divider
    import tempo_pkg::*;
#(
    parameter  int CHANNELS  = DEF_CHANNELS,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int RESET_DIV = DEF_RESET_DIV,
    localparam int SEL_W     = sel_width(CHANNELS)
) (
    input  logic                clk_rx,
    input  logic                nrst,
    input  logic                en,
    input  logic                sync,
    input  logic                div_we,
    input  logic [SEL_W-1:0]    div_sel,
    input  logic [WIDTH-1:0]    div_data,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] clk_tx
);

    logic [CHANNELS-1:0] we_s;

    // Decode the shared write port into one strobe per channel; a select
    // beyond the last channel matches nothing and the write is dropped.
    always_comb begin
        we_s = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (div_we && (div_sel == SEL_W'(i))) begin
                we_s[i] = 1'b1;
            end else begin
                we_s[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        div_channel #(
            .WIDTH     (WIDTH),
            .RESET_DIV (RESET_DIV)
        ) u_chan (
            .clk_rx (clk_rx),
            .nrst   (nrst),
            .en     (en),
            .sync   (sync),
            .we     (we_s[g]),
            .data   (div_data),
            .tick   (tick[g]),
            .clk_tx (clk_tx[g])
        );
    end

endmodule : tempo_divider

// File: tb/tb_tempo_divider.sv
module tb_tempo_divider;

    localparam int CH    = 4;
    localparam int W     = 16;
    localparam int SEL_W = 2;

    logic             clk_rx = 1'b0;
    logic             nrst;
    logic             en;
    logic             sync;
    logic             div_we;
    logic [SEL_W-1:0] div_sel;
    logic [W-1:0]     div_data;
    logic [CH-1:0]    tick;
    logic [CH-1:0]    clk_tx;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: per channel, the pending divisor and the number of
    // enabled cycles still to go before the next tick.
    int            m_s   [CH];
    int            m_rem [CH];
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_clk;

    always #5 clk_rx = ~clk_rx;

    tempo_divider #(.CHANNELS(CH), .WIDTH(W), .RESET_DIV(3)) dut (
        .clk_rx   (clk_rx),
        .nrst     (nrst),
        .en       (en),
        .sync     (sync),
        .div_we   (div_we),
        .div_sel  (div_sel),
        .div_data (div_data),
        .tick     (tick),
        .clk_tx   (clk_tx)
    );

    task automatic m_reset();
        for (int c = 0; c < CH; c++) begin
            m_s[c]   = 3;
            m_rem[c] = 4;
        end
        m_tick = '0;
        m_clk  = '0;
    endtask

    task automatic m_step();
        if (div_we && int'(div_sel) < CH) m_s[div_sel] = int'(div_data);
        for (int c = 0; c < CH; c++) begin
            if (sync) begin
                m_rem[c]  = m_s[c] + 1;
                m_tick[c] = 1'b0;
                m_clk[c]  = 1'b0;
            end else if (!en) begin
                m_tick[c] = 1'b0;
            end else begin
                m_rem[c] = m_rem[c] - 1;
                if (m_rem[c] == 0) begin
                    m_tick[c] = 1'b1;
                    m_clk[c]  = ~m_clk[c];
                    m_rem[c]  = m_s[c] + 1;
                end else begin
                    m_tick[c] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk_rx);
        m_step();
        #1;
    endtask

    task automatic idle_inputs();
        en = 1'b0; sync = 1'b0; div_we = 1'b0; div_sel = '0; div_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk_rx);
        nrst = 1'b0;
        m_reset();
        @(negedge clk_rx);
        nrst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge clk_rx);
        nrst = 1'b0;
        #1;
        tests_run++;
        if (tick !== 4'b0000 || clk_tx !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_async: tick=%b clk_tx=%b expected 0000/0000", tick, clk_tx);
        end
        @(posedge clk_rx); #1;
        tests_run++;
        if (tick !== 4'b0000 || clk_tx !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_held: tick=%b clk_tx=%b expected 0000/0000", tick, clk_tx);
        end
        m_reset();
        @(negedge clk_rx);
        nrst = 1'b1;
    endtask

    task automatic test_basic_count();
        int first0, rise1, rise2;
        first0 = -1; rise1 = -1; rise2 = -1;
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            logic prev;
            prev = clk_tx[0];
            step();
            tests_run++;
            if (tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL basic_cycle %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
            if (first0 < 0 && tick[0] === 1'b1) first0 = n;
            if (prev === 1'b0 && clk_tx[0] === 1'b1) begin
                if (rise1 < 0) rise1 = n;
                else if (rise2 < 0) rise2 = n;
            end
        end
        tests_run++;
        if (first0 !== 4) begin
            tests_failed++;
            $display("FAIL basic_first_tick: edge %0d expected 4", first0);
        end
        tests_run++;
        if (rise2 - rise1 !== 8) begin
            tests_failed++;
            $display("FAIL basic_clk_period: %0d expected 8", rise2 - rise1);
        end
    endtask

    task automatic test_div_write();
        int q[$];
        int exp_edges[5] = '{4, 14, 24, 34, 44};
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            if (n == 2) begin
                div_we = 1'b1; div_sel = 2'd1; div_data = 16'd9;
            end else begin
                div_we = 1'b0;
            end
            step();
            tests_run++;
            if (tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL divwr_cycle %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
            if (tick[1] === 1'b1) q.push_back(n);
        end
        tests_run++;
        if (q.size() != 5) begin
            tests_failed++;
            $display("FAIL divwr_count: %0d ticks expected 5", q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                tests_run++;
                if (q[k] !== exp_edges[k]) begin
                    tests_failed++;
                    $display("FAIL divwr_edge %0d: edge %0d expected %0d", k, q[k], exp_edges[k]);
                end
            end
        end
    endtask

    task automatic test_d0_wrap();
        int gap;
        logic prev;
        do_reset();
        en = 1'b1;
        div_we = 1'b1; div_sel = 2'd2; div_data = 16'd0;
        step();
        div_we = 1'b0;
        for (int n = 2; n <= 4; n++) step();
        for (int n = 5; n <= 10; n++) begin
            prev = clk_tx[2];
            step();
            tests_run++;
            if (tick[2] !== 1'b1 || clk_tx[2] !== ~prev || tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL d0_cycle %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
        end
        div_we = 1'b1; div_sel = 2'd2; div_data = 16'd5;
        step();
        div_we = 1'b0;
        tests_run++;
        if (tick[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL d0_wrap_tick: tick[2]=%b expected 1", tick[2]);
        end
        gap = -1;
        for (int n = 1; n <= 20 && gap < 0; n++) begin
            step();
            tests_run++;
            if (tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL d0_after %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
            if (tick[2] === 1'b1) gap = n;
        end
        tests_run++;
        if (gap !== 6) begin
            tests_failed++;
            $display("FAIL d0_new_interval: %0d expected 6", gap);
        end
    endtask

    task automatic test_sync();
        int first [CH];
        int exp_first [CH] = '{2, 3, 8, 5};
        do_reset();
        en = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            div_we = 1'b1;
            case (n)
                1:       begin div_sel = 2'd0; div_data = 16'd1; end
                2:       begin div_sel = 2'd1; div_data = 16'd2; end
                3:       begin div_sel = 2'd3; div_data = 16'd5; end
                13:      begin div_sel = 2'd2; div_data = 16'd7; end
                default: div_we = 1'b0;
            endcase
            step();
        end
        sync = 1'b1; div_we = 1'b1; div_sel = 2'd3; div_data = 16'd4;
        step();
        sync = 1'b0; div_we = 1'b0;
        tests_run++;
        if (tick !== 4'b0000 || clk_tx !== 4'b0000) begin
            tests_failed++;
            $display("FAIL sync_edge: tick=%b clk_tx=%b expected 0000/0000", tick, clk_tx);
        end
        for (int c = 0; c < CH; c++) first[c] = -1;
        for (int n = 1; n <= 20; n++) begin
            step();
            tests_run++;
            if (tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL sync_cycle %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
            for (int c = 0; c < CH; c++)
                if (first[c] < 0 && tick[c] === 1'b1) first[c] = n;
        end
        for (int c = 0; c < CH; c++) begin
            tests_run++;
            if (first[c] !== exp_first[c]) begin
                tests_failed++;
                $display("FAIL sync_first_tick ch%0d: %0d expected %0d", c, first[c], exp_first[c]);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [CH-1:0] held;
        int gap;
        do_reset();
        en = 1'b1;
        step();
        step();
        en = 1'b0;
        held = clk_tx;
        for (int n = 1; n <= 5; n++) begin
            step();
            tests_run++;
            if (tick !== 4'b0000 || clk_tx !== held || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL hold_cycle %0d: tick=%b clk_tx=%b expected 0000/%b", n, tick, clk_tx, held);
            end
        end
        en = 1'b1;
        gap = -1;
        for (int n = 1; n <= 10 && gap < 0; n++) begin
            step();
            if (tick[0] === 1'b1) gap = n;
        end
        tests_run++;
        if (gap !== 2) begin
            tests_failed++;
            $display("FAIL hold_resume: tick after %0d expected 2", gap);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 1; n <= 1500; n++) begin
            en     = ($urandom_range(0, 7) != 0);
            sync   = ($urandom_range(0, 49) == 0);
            div_we = ($urandom_range(0, 5) == 0);
            div_sel = SEL_W'($urandom_range(0, CH - 1));
            if ($urandom_range(0, 39) == 0) div_data = 16'hFFFF;
            else div_data = W'($urandom_range(0, 7));
            step();
            tests_run++;
            if (tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL random_cycle %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
        end
        idle_inputs();
    endtask

    task automatic test_async_reset();
        int found, first;
        do_reset();
        en = 1'b1;
        found = 0;
        for (int n = 1; n <= 20 && found == 0; n++) begin
            step();
            if (m_clk[0] === 1'b1) found = 1;
        end
        tests_run++;
        if (found == 0 || clk_tx[0] !== 1'b1) begin
            tests_failed++;
            $display("FAIL arst_setup: clk_tx[0]=%b expected 1", clk_tx[0]);
        end
        #2;
        nrst = 1'b0;
        #1;
        tests_run++;
        if (tick !== 4'b0000 || clk_tx !== 4'b0000) begin
            tests_failed++;
            $display("FAIL arst_immediate: tick=%b clk_tx=%b expected 0000/0000", tick, clk_tx);
        end
        m_reset();
        @(negedge clk_rx);
        nrst = 1'b1;
        first = -1;
        for (int n = 1; n <= 12; n++) begin
            step();
            tests_run++;
            if (tick !== m_tick || clk_tx !== m_clk) begin
                tests_failed++;
                $display("FAIL arst_cycle %0d: tick=%b clk_tx=%b expected %b/%b", n, tick, clk_tx, m_tick, m_clk);
            end
            if (first < 0 && tick[0] === 1'b1) first = n;
        end
        tests_run++;
        if (first !== 4) begin
            tests_failed++;
            $display("FAIL arst_first_tick: edge %0d expected 4", first);
        end
    endtask

    initial begin
        nrst = 1'b0;
        idle_inputs();
        m_reset();
        test_reset();
        test_basic_count();
        test_div_write();
        test_d0_wrap();
        test_sync();
        test_enable_hold();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_tempo_divider
